mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares one single-port, fixed-latency memory between two requesters: port 0 is the MEM-stage data access, port 1 is instruction fetch.
- Sequences every access: grant, single-cycle memory enable, latency wait, read-data capture, done pulse.
- Sits between the pipeline stage logic and the memory array. Its captured rdata feeds the 32-bit pipeline registers downstream.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- MEM_LAT, 2, cycles from the mem_en cycle to the edge that samples mem_rdata. Legal range ≥1.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  2  per-port request; bit0 = data, bit1 = fetch.
- we  in  2  per-port write enable; qualified by req.
- addr0, addr1  in  AW  per-port address.
- wdata0, wdata1  in  DW  per-port write data.
- gnt  out  2  one-hot owner of the memory; 0 when idle.
- done  out  2  one-cycle completion pulse to the owner.
- rdata  out  DW  last read result, registered.
- busy  out  1  high in ACCESS or DONE.
- mem_en  out  1  memory strobe, one cycle per access.
- mem_we  out  1  write strobe, coincident with mem_en.
- mem_addr  out  AW  latched address.
- mem_wdata  out  DW  latched write data.
- mem_rdata  in  DW  memory read data.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, cnt=0, last_owner=1.
  - gnt, done, busy, mem_en, mem_we = 0.
  - mem_addr, mem_wdata, rdata = 0.
  - Reset mid-access aborts the access: no done pulse, memory strobes drop immediately.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - If any req bit is set, choose owner. Single request: that port. Both set: the port ≠ last_owner (round-robin).
  - Next edge: latch owner's addr, wdata and we into mem_addr, mem_wdata and mem_we. Set gnt one-hot, last_owner=owner, cnt=0, state=ACCESS.
- ACCESS:
  - mem_en=1 in the first ACCESS cycle only. mem_we follows the latched we in that cycle and is 0 otherwise.
  - cnt increments each cycle.
  - When cnt==MEM_LAT-1: next edge captures mem_rdata into rdata (reads only; writes leave rdata unchanged) and goes to DONE.
- DONE:
  - Lasts 1 cycle. done[owner]=1 and gnt held.
  - All requests are ignored, which gives the requester one cycle to drop req.
  - Next state is IDLE with gnt=0.
- Latency: req sampled in IDLE at cycle T → mem_en at T+1 → done at T+1+MEM_LAT.
  - Next grant is possible at T+2+MEM_LAT.
  - Throughput: one access per MEM_LAT+2 cycles.
- Owner dropping req during ACCESS: the access still completes and done still pulses.
- Request inputs (req, we, addr, wdata) of the non-owner are ignored until the arbiter returns to IDLE.
- A req still high in IDLE after DONE is treated as a new request.
- Outputs gnt, done, busy, mem_en, mem_we and rdata are registered; there are no combinational paths from inputs to outputs.

Decomposition:
- Shared package holds:
  - state encoding constants IDLE=2'd0, ACCESS=2'd1, DONE=2'd2;
  - port indices PORT_DATA=0, PORT_FETCH=1;
  - MEM_LAT default.
- Single module. The round-robin choice is one expression, and a separate sub-module is not warranted.

Test Plan:
- Reset → all outputs 0; release with req=2'b01, we=0, addr0=0x10, MEM_LAT=2: mem_en at cycle 1 with mem_addr=0x10; mem_rdata=0xDEADBEEF sampled; done=2'b01 and rdata=0xDEADBEEF at cycle 3.
- Write: req=2'b10, we=2'b10, addr1=0x20, wdata1=0x1234 → mem_we=1 for exactly one cycle with mem_wdata=0x1234; done=2'b10; rdata unchanged.
- Contention: req=2'b11 held for 4 accesses after reset → grant order 0,1,0,1; each done spaced 4 cycles apart.
- Owner drops req during ACCESS → done still pulses; gnt returns to 0 after DONE; no extra mem_en.
- rst_n low during ACCESS cycle 2 → gnt, busy and mem_en go to 0 asynchronously; no done; next request after release sees a full MEM_LAT latency.
- MEM_LAT=1 build: req at T → mem_en T+1, done T+2; continuous req=2'b01 → mem_en every 3 cycles.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants for the two-port memory arbiter:
// FSM encoding, requester indices and default latency.
package mem_port_arbiter_pkg;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;

  localparam logic PORT_DATA  = 1'b0;
  localparam logic PORT_FETCH = 1'b1;

  localparam int MEM_LAT_DEF = 2;

endpackage

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one fixed-latency memory
// between the MEM-stage data port and instruction fetch.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MEM_LAT = MEM_LAT_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [1:0]    req,
  input  logic [1:0]    we,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic [1:0]    gnt,
  output logic [1:0]    done,
  output logic [DW-1:0] rdata,
  output logic          busy,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int CW = $clog2(MEM_LAT + 1);

  logic [1:0]    state;
  logic [1:0]    state_d;
  logic [CW-1:0] cnt;
  logic          last_owner;
  logic          we_lat;
  logic          pick;
  logic          cnt_last;
  logic          start;

  logic [1:0]    gnt_d;
  logic [1:0]    done_d;
  logic          busy_d;
  logic          en_d;
  logic          mwe_d;

  // Contention goes to whoever did not own the last access.
  assign pick = (req == 2'b11) ? ~last_owner
              : (req[1] ? PORT_FETCH : PORT_DATA);

  assign cnt_last = (cnt == CW'(MEM_LAT - 1));
  assign start    = (state == IDLE) && (|req);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:    if (|req) state_d = ACCESS;
      ACCESS:  if (cnt_last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    gnt_d  = gnt;
    done_d = 2'b00;
    en_d   = 1'b0;
    mwe_d  = 1'b0;
    busy_d = (state_d != IDLE);
    unique case (state)
      IDLE: begin
        if (|req) begin
          gnt_d = 2'b01 << pick;
          en_d  = 1'b1;
          mwe_d = we[pick];
        end
      end
      ACCESS:  if (cnt_last) done_d = gnt;
      DONE:    gnt_d = 2'b00;
      default: gnt_d = 2'b00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt        <= 2'b00;
      done       <= 2'b00;
      busy       <= 1'b0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      rdata      <= '0;
      cnt        <= '0;
      last_owner <= PORT_FETCH;
      we_lat     <= 1'b0;
    end else begin
      gnt    <= gnt_d;
      done   <= done_d;
      busy   <= busy_d;
      mem_en <= en_d;
      mem_we <= mwe_d;
      if (start) begin
        last_owner <= pick;
        cnt        <= '0;
        we_lat     <= we[pick];
        mem_addr   <= (pick == PORT_FETCH) ? addr1 : addr0;
        mem_wdata  <= (pick == PORT_FETCH) ? wdata1 : wdata0;
      end else if (state == ACCESS) begin
        cnt <= cnt + CW'(1);
        if (cnt_last && !we_lat) rdata <= mem_rdata;
      end
    end
  end

endmodule
